// File: rtl/fight_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fight_resolver: per-frame hit detection, health/hitstun, round FSM         |
// | Optional: GUARD_EN enables guard blocking (chip damage, half hitstun)      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fight_resolver #(
  parameter int POS_WIDTH       = 10,
  parameter int HP_MAX          = 100,
  parameter int DMG_LIGHT       = 5,
  parameter int DMG_HEAVY       = 12,
  parameter int REACH_LIGHT     = 40,
  parameter int REACH_HEAVY     = 64,
  parameter int Y_TOL           = 24,
  parameter int HIT_FRAME_LIGHT = 3,
  parameter int HIT_FRAME_HEAVY = 6,
  parameter int HITSTUN_FRAMES  = 12,
  parameter int INTRO_FRAMES    = 60,
  parameter int KO_FRAMES       = 90
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SCEN,
  input  logic                 start,
  input  logic [POS_WIDTH-1:0] p1_x,
  input  logic [POS_WIDTH-1:0] p2_x,
  input  logic [POS_WIDTH-1:0] p1_y,
  input  logic [POS_WIDTH-1:0] p2_y,
  input  logic                 p1_face_right,
  input  logic                 p2_face_right,
  input  logic                 p1_attack_active,
  input  logic                 p2_attack_active,
  input  logic [1:0]           p1_attack_type,
  input  logic [1:0]           p2_attack_type,
  input  logic [5:0]           p1_attack_frame,
  input  logic [5:0]           p2_attack_frame,
  input  logic                 p1_guard,
  input  logic                 p2_guard,
  output logic                 p1_hitstun,
  output logic                 p2_hitstun,
  output logic [7:0]           p1_health,
  output logic [7:0]           p2_health,
  output logic [1:0]           round_state,
  output logic [1:0]           winner,
  output logic                 controls_enable,
  output logic [1:0]           hit_event
);

  localparam int CNT_MAX = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HS_W    = $clog2(HITSTUN_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INTRO  = 2'd1,
    ST_FIGHT  = 2'd2,
    ST_KO_END = 2'd3
  } round_t;

  round_t            round_q, round_d;
  logic              ko_done_q, ko_done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
  logic [HS_W-1:0]   p1_stun_q, p1_stun_d, p2_stun_q, p2_stun_d;
  logic [1:0]        winner_q, winner_d;
  logic [1:0]        hit_event_q, hit_event_d;
  logic              controls_q;

  logic              hit_p1, hit_p2;
  logic [7:0]        dmg_p1, dmg_p2;
  logic [HS_W-1:0]   stun_p1, stun_p2;

  function automatic logic hit_check(
    input logic [POS_WIDTH-1:0] xa, ya, xd, yd,
    input logic                 face_right,
    input logic                 active,
    input logic [1:0]           atype,
    input logic [5:0]           aframe,
    input logic [HS_W-1:0]      d_stun
  );
    logic [POS_WIDTH-1:0] dx, dy;
    logic on_frame, in_reach, facing;
    dx       = (xa >= xd) ? (xa - xd) : (xd - xa);
    dy       = (ya >= yd) ? (ya - yd) : (yd - ya);
    on_frame = 1'b0;
    in_reach = 1'b0;
    case (atype)
      2'd1: begin
        on_frame = (aframe == 6'(HIT_FRAME_LIGHT));
        in_reach = (dx <= POS_WIDTH'(REACH_LIGHT));
      end
      2'd2: begin
        on_frame = (aframe == 6'(HIT_FRAME_HEAVY));
        in_reach = (dx <= POS_WIDTH'(REACH_HEAVY));
      end
      default: ;
    endcase
    facing = face_right ? (xd >= xa) : (xd <= xa);
    return active && on_frame && in_reach && (dy <= POS_WIDTH'(Y_TOL)) && facing &&
           (d_stun == '0);
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] hp, input logic [7:0] dmg);
    return (hp <= dmg) ? 8'd0 : (hp - dmg);
  endfunction

  always_comb begin
    dmg_p1  = (p2_attack_type == 2'd2) ? 8'(DMG_HEAVY) : 8'(DMG_LIGHT);
    dmg_p2  = (p1_attack_type == 2'd2) ? 8'(DMG_HEAVY) : 8'(DMG_LIGHT);
    stun_p1 = HS_W'(HITSTUN_FRAMES);
    stun_p2 = HS_W'(HITSTUN_FRAMES);
`ifdef GUARD_EN
    // A guarding defender that is not itself attacking only takes chip damage
    if (p1_guard && !p1_attack_active) begin
      dmg_p1  = 8'd1;
      stun_p1 = HS_W'(HITSTUN_FRAMES / 2);
    end
    if (p2_guard && !p2_attack_active) begin
      dmg_p2  = 8'd1;
      stun_p2 = HS_W'(HITSTUN_FRAMES / 2);
    end
`endif
  end

`ifndef GUARD_EN
  logic unused_guard;
  assign unused_guard = p1_guard ^ p2_guard;
`endif

  always_comb begin
    round_d     = round_q;
    ko_done_d   = ko_done_q;
    cnt_d       = cnt_q;
    p1_hp_d     = p1_hp_q;
    p2_hp_d     = p2_hp_q;
    p1_stun_d   = p1_stun_q;
    p2_stun_d   = p2_stun_q;
    winner_d    = winner_q;
    hit_event_d = 2'b00;
    hit_p1      = 1'b0;
    hit_p2      = 1'b0;
    if (SCEN) begin
      p1_stun_d = (p1_stun_q != '0) ? (p1_stun_q - 1'b1) : '0;
      p2_stun_d = (p2_stun_q != '0) ? (p2_stun_q - 1'b1) : '0;
      case (round_q)
        ST_IDLE, ST_KO_END: begin
          if (round_q == ST_KO_END && !ko_done_q) begin
            if (cnt_q == CNT_W'(KO_FRAMES - 1)) ko_done_d = 1'b1;
            else                                 cnt_d     = cnt_q + 1'b1;
          end else if (start) begin
            round_d   = ST_INTRO;
            ko_done_d = 1'b0;
            cnt_d     = '0;
            p1_hp_d   = 8'(HP_MAX);
            p2_hp_d   = 8'(HP_MAX);
            p1_stun_d = '0;
            p2_stun_d = '0;
            winner_d  = 2'd0;
          end
        end
        ST_INTRO: begin
          if (cnt_q == CNT_W'(INTRO_FRAMES - 1)) begin
            round_d = ST_FIGHT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FIGHT: begin
          hit_p2 = hit_check(p1_x, p1_y, p2_x, p2_y, p1_face_right, p1_attack_active,
                             p1_attack_type, p1_attack_frame, p2_stun_q);
          hit_p1 = hit_check(p2_x, p2_y, p1_x, p1_y, p2_face_right, p2_attack_active,
                             p2_attack_type, p2_attack_frame, p1_stun_q);
          if (hit_p1) begin
            p1_hp_d   = sat_sub(p1_hp_q, dmg_p1);
            p1_stun_d = stun_p1;
          end
          if (hit_p2) begin
            p2_hp_d   = sat_sub(p2_hp_q, dmg_p2);
            p2_stun_d = stun_p2;
          end
          hit_event_d = {hit_p2, hit_p1};
          if (p1_hp_d == 8'd0 || p2_hp_d == 8'd0) begin
            round_d   = ST_KO_END;
            ko_done_d = 1'b0;
            cnt_d     = '0;
            if (p1_hp_d == 8'd0 && p2_hp_d == 8'd0) winner_d = 2'd3;
            else if (p1_hp_d == 8'd0)                winner_d = 2'd2;
            else                                     winner_d = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_q     <= ST_IDLE;
      ko_done_q   <= 1'b0;
      cnt_q       <= '0;
      p1_hp_q     <= 8'(HP_MAX);
      p2_hp_q     <= 8'(HP_MAX);
      p1_stun_q   <= '0;
      p2_stun_q   <= '0;
      winner_q    <= 2'd0;
      hit_event_q <= 2'b00;
      controls_q  <= 1'b0;
    end else begin
      round_q     <= round_d;
      ko_done_q   <= ko_done_d;
      cnt_q       <= cnt_d;
      p1_hp_q     <= p1_hp_d;
      p2_hp_q     <= p2_hp_d;
      p1_stun_q   <= p1_stun_d;
      p2_stun_q   <= p2_stun_d;
      winner_q    <= winner_d;
      hit_event_q <= hit_event_d;
      controls_q  <= (round_d == ST_FIGHT);
    end
  end

  assign p1_hitstun      = (p1_stun_q != '0);
  assign p2_hitstun      = (p2_stun_q != '0);
  assign p1_health       = p1_hp_q;
  assign p2_health       = p2_hp_q;
  assign round_state     = round_q;
  assign winner          = winner_q;
  assign controls_enable = controls_q;
  assign hit_event       = hit_event_q;

endmodule
`default_nettype wire

// File: tb/tb_fight_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fight_resolver: directed stimulus with a hit-event scoreboard           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fight_resolver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       SCEN = 1'b0;
  logic       start = 1'b0;
  logic [9:0] p1_x = 10'd100, p2_x = 10'd130, p1_y = 10'd200, p2_y = 10'd200;
  logic       p1_face_right = 1'b1, p2_face_right = 1'b0;
  logic       p1_attack_active = 1'b0, p2_attack_active = 1'b0;
  logic [1:0] p1_attack_type = 2'd0, p2_attack_type = 2'd0;
  logic [5:0] p1_attack_frame = 6'd0, p2_attack_frame = 6'd0;
  logic       p1_guard = 1'b0, p2_guard = 1'b0;
  logic       p1_hitstun, p2_hitstun, controls_enable;
  logic [7:0] p1_health, p2_health;
  logic [1:0] round_state, winner, hit_event;

  fight_resolver dut (
    .clk(clk), .reset(reset), .SCEN(SCEN), .start(start),
    .p1_x(p1_x), .p2_x(p2_x), .p1_y(p1_y), .p2_y(p2_y),
    .p1_face_right(p1_face_right), .p2_face_right(p2_face_right),
    .p1_attack_active(p1_attack_active), .p2_attack_active(p2_attack_active),
    .p1_attack_type(p1_attack_type), .p2_attack_type(p2_attack_type),
    .p1_attack_frame(p1_attack_frame), .p2_attack_frame(p2_attack_frame),
    .p1_guard(p1_guard), .p2_guard(p2_guard),
    .p1_hitstun(p1_hitstun), .p2_hitstun(p2_hitstun),
    .p1_health(p1_health), .p2_health(p2_health),
    .round_state(round_state), .winner(winner),
    .controls_enable(controls_enable), .hit_event(hit_event)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ev;
    logic [7:0] h1;
    logic [7:0] h2;
    logic [1:0] rs;
    logic [1:0] win;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef GUARD_EN
  localparam int GUARD_HP   = 99;
  localparam int GUARD_STUN = 6;
`else
  localparam int GUARD_HP   = 88;
  localparam int GUARD_STUN = 12;
`endif

  // Scoreboard monitor: every visible hit_event pulse consumes one expectation
  always @(negedge clk) begin
    exp_t act, e;
    if (reset && hit_event !== 2'b00) begin
      act = '{ev: hit_event, h1: p1_health, h2: p2_health, rs: round_state, win: winner};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hit got ev=%b h1=%0d h2=%0d required no hit_event",
                 hit_event, p1_health, p2_health);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL hit_record got ev=%b h1=%0d h2=%0d rs=%0d win=%0d required ev=%b h1=%0d h2=%0d rs=%0d win=%0d",
                   act.ev, act.h1, act.h2, act.rs, act.win, e.ev, e.h1, e.h2, e.rs, e.win);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    SCEN = 1'b1;
    @(negedge clk);
    SCEN = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_hit(input logic [1:0] ev, input int h1, input int h2,
                            input int rs, input int win);
    exp_q.push_back('{ev: ev, h1: 8'(h1), h2: 8'(h2), rs: 2'(rs), win: 2'(win)});
  endtask

  task automatic p1_strike(input logic [1:0] t, input logic [5:0] f);
    p1_attack_active = 1'b1;
    p1_attack_type   = t;
    p1_attack_frame  = f;
    tick();
    p1_attack_active = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_round_state", round_state, 0);
    chk("rst_p1_health", p1_health, 100);
    chk("rst_p2_health", p2_health, 100);
    chk("rst_outputs", {winner, controls_enable, p1_hitstun, p2_hitstun, hit_event}, 0);
    reset = 1'b1;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("intro_entry", round_state, 1);
    idle(59);
    chk("intro_still_59", round_state, 1);
    tick();
    chk("fight_entry", round_state, 2);
    chk("fight_controls", controls_enable, 1);
    chk("fight_health", {p1_health, p2_health}, {8'd100, 8'd100});

    // Light attack walked through frames 0..5, connects on frame 3
    for (int f = 0; f < 6; f++) begin
      if (f == 3) expect_hit(2'b10, 100, 95, 2, 0);
      p1_attack_active = 1'b1;
      p1_attack_type   = 2'd1;
      p1_attack_frame  = 6'(f);
      tick();
    end
    p1_attack_active = 1'b0;
    idle(9);
    chk("stun_after_12", p2_hitstun, 1);
    tick();
    chk("stun_cleared_13", p2_hitstun, 0);

    p2_x = 10'd150;
    for (int f = 0; f < 6; f++) p1_strike(2'd1, 6'(f));
    chk("light_out_of_reach", p2_health, 95);
    for (int f = 0; f < 8; f++) begin
      if (f == 6) expect_hit(2'b10, 100, 83, 2, 0);
      p1_strike(2'd2, 6'(f));
    end
    idle(12);

    p2_x = 10'd140;
    expect_hit(2'b10, 100, 78, 2, 0);
    p1_strike(2'd1, 6'd3);
    idle(12);

    p2_x = 10'd130;
    p1_face_right = 1'b0;
    p1_strike(2'd1, 6'd3);
    chk("wrong_facing", p2_health, 78);
    p1_face_right = 1'b1;
    p2_y = 10'd225;
    p1_strike(2'd1, 6'd3);
    chk("y_out_of_tol", p2_health, 78);
    p2_y = 10'd224;
    expect_hit(2'b10, 100, 73, 2, 0);
    p1_strike(2'd1, 6'd3);
    p2_y = 10'd200;
    idle(12);

    // Trade: both heavies land on the same frame
    expect_hit(2'b11, 88, 61, 2, 0);
    p2_attack_active = 1'b1;
    p2_attack_type   = 2'd2;
    p2_attack_frame  = 6'd6;
    p1_strike(2'd2, 6'd6);
    p2_attack_active = 1'b0;
    chk("trade_stun", {p1_hitstun, p2_hitstun}, 2'b11);
    idle(12);

    for (int k = 1; k <= 5; k++) begin
      expect_hit(2'b10, 88, 61 - 12 * k, 2, 0);
      p1_strike(2'd2, 6'd6);
      idle(12);
    end
    expect_hit(2'b10, 88, 0, 3, 1);
    p1_strike(2'd2, 6'd6);
    chk("ko_round_state", round_state, 3);
    chk("ko_controls", controls_enable, 0);
    chk("ko_winner", winner, 1);

    start = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      tick();
      if (i == 11) chk("ko_stun_11", p2_hitstun, 1);
      if (i == 12) chk("ko_stun_12", p2_hitstun, 0);
    end
    chk("ko_hold_90", round_state, 3);
    chk("ko_health_kept", {p1_health, p2_health}, {8'd88, 8'd0});
    tick();
    start = 1'b0;
    chk("restart_intro", round_state, 1);
    chk("restart_health", {p1_health, p2_health}, {8'd100, 8'd100});
    chk("restart_winner", winner, 0);
    idle(60);
    chk("round2_fight", round_state, 2);

    p2_guard = 1'b1;
    expect_hit(2'b10, 100, GUARD_HP, 2, 0);
    p1_strike(2'd2, 6'd6);
    idle(GUARD_STUN - 1);
    chk("guard_stun_last", p2_hitstun, 1);

    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", round_state, 0);
    chk("async_rst_health", {p1_health, p2_health}, {8'd100, 8'd100});
    chk("async_rst_outputs", {winner, controls_enable, p1_hitstun, p2_hitstun, hit_event}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fight_resolver.md
Name: fight_resolver

Overview:
- Round and combat controller between the two player_core instances and the display/HUD.
- Every frame tick (SCEN) it checks each player's attack against the opponent's position.
- On a hit it applies damage to health, drives the defender's hitstun_active for a fixed number of frames, and runs the round FSM (intro, fight, KO, end).
- It gates player controls through controls_enable.

Parameters:
- POS_WIDTH, 10, width of the x/y position buses.
- HP_MAX, 100, starting health per player (must fit in 8 bits).
- DMG_LIGHT, 5, damage for attack_type 2'd1.
- DMG_HEAVY, 12, damage for attack_type 2'd2.
- REACH_LIGHT, 40, max |dx| in pixels for a light hit.
- REACH_HEAVY, 64, max |dx| in pixels for a heavy hit.
- Y_TOL, 24, max |dy| in pixels for any hit.
- HIT_FRAME_LIGHT, 3, attack_frame value on which a light attack connects.
- HIT_FRAME_HEAVY, 6, attack_frame value on which a heavy attack connects.
- HITSTUN_FRAMES, 12, hitstun duration in frames.
- INTRO_FRAMES, 60, frames spent in INTRO.
- KO_FRAMES, 90, frames spent in KO before END.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- SCEN  in  1  one-cycle frame tick; all state advances only on clk edges with SCEN=1
- start  in  1  level; begins a round from IDLE or END
- p1_x, p2_x  in  POS_WIDTH  player x positions
- p1_y, p2_y  in  POS_WIDTH  player y positions
- p1_face_right, p2_face_right  in  1  facing direction
- p1_attack_active, p2_attack_active  in  1  attack in progress
- p1_attack_type, p2_attack_type  in  2  attack type: 1 light, 2 heavy, other values never hit
- p1_attack_frame, p2_attack_frame  in  6  current attack frame
- p1_guard, p2_guard  in  1  holding away from opponent (used only with GUARD_EN)
- p1_hitstun, p2_hitstun  out  1  to each player_core hitstun_active input
- p1_health, p2_health  out  8  current health
- round_state  out  2  0 IDLE, 1 INTRO, 2 FIGHT, 3 KO_END
- winner  out  2  0 none, 1 P1, 2 P2, 3 draw
- controls_enable  out  1  high only in FIGHT
- hit_event  out  2  bit0 P1 was hit, bit1 P2 was hit; one-clk pulse

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE; health = HP_MAX for both players.
  - Hitstun counters = 0; all 1-bit outputs = 0; winner = 0.
- IDLE: on SCEN with start=1, go to INTRO. Health reloads to HP_MAX, winner cleared, hitstun cleared, frame counter = 0.
- INTRO: the frame counter increments per SCEN. On the SCEN where the counter reaches INTRO_FRAMES-1, go to FIGHT.
- FIGHT: controls_enable=1. Hit evaluation runs on each SCEN edge.
- KO_END, sub-phase KO: the counter runs KO_FRAMES; controls_enable=0; hitstun counters keep decrementing. The FSM then holds in KO_END (END sub-phase) until SCEN with start=1, which goes to INTRO with a full reload.
- Hit by A on D, evaluated per SCEN in FIGHT only. All of the following must hold:
  - A attack_active=1.
  - attack_type is 1 or 2.
  - attack_frame equals the matching HIT_FRAME.
  - |xA-xD| <= the matching REACH.
  - |yA-yD| <= Y_TOL.
  - Facing: A face_right=1 requires xD >= xA; face_right=0 requires xD <= xA.
  - D hitstun counter = 0.
- Distance arithmetic is unsigned subtraction of the larger minus the smaller value, at POS_WIDTH bits; no wrap.
- Both directions are evaluated from the same sampled inputs. A simultaneous trade applies both hits.
- Effect of a hit (registered on the same SCEN edge, visible the next clk):
  - D health = max(0, health - dmg); saturates, never wraps.
  - D hitstun counter = HITSTUN_FRAMES.
  - hit_event bit pulses for exactly one clk.
- Hitstun: pN_hitstun = (counter != 0). The counter decrements on each SCEN, floors at 0, and is not reloaded while nonzero.
- KO: when, after the update, either health = 0, go to KO_END on that same edge.
  - winner = 3 if both are 0; otherwise the survivor.
  - Hits that were applied on that edge remain applied.
- SCEN=0: all registers hold; hit_event = 0.
- start is ignored in INTRO and FIGHT, and during the KO sub-phase.

Optional Feature:
- GUARD_EN defined: a hit on D while pD_guard=1 and D attack_active=0 is blocked.
  - Damage = 1 (saturating).
  - Hitstun = HITSTUN_FRAMES/2 (integer division).
  - hit_event still pulses.
- Undefined: the guard inputs are ignored and every hit takes full damage and full hitstun.

Test Plan:
- Reset, then start held for 1 SCEN -> round_state 1. After 60 SCEN -> round_state 2, controls_enable=1, both health 100.
- P1 at x=100, P2 at x=130, same y, p1_face_right=1, P1 light attack frames 0..5 -> one hit_event[1] pulse on the frame-3 SCEN; p2_health=95; p2_hitstun high for exactly 12 SCEN.
- Same setup with P2 at x=150 (dx=50 > 40) -> no hit. Repeat as a heavy attack with frame 6 -> p2_health=88.
- Both players heavy-attack facing each other, dx=30, both on frame 6 on the same SCEN -> both health 88 and hit_event=2'b11.
- P2 health at 4, P1 light hit lands -> p2_health=0 (not 255), round_state 3, winner=1, controls_enable=0 on the next clk. After 90 SCEN plus start -> INTRO with health 100.
- GUARD_EN build: p2_guard=1, P2 idle, P1 heavy hit lands -> p2_health 99, hitstun 6 SCEN. Assert reset mid-FIGHT -> IDLE immediately with all outputs at reset values.
